// File: rtl/game_round_engine.sv
// Purpose: reaction-game round engine; round timer, LFSR target selection, hit/miss scoring.
// Latency: outputs registered, one cycle after the sampled button edge or timer event.
// Backpressure: none; button edges are consumed every cycle and never stalled.
module game_round_engine #(
  parameter int CLKS_PER_SEC  = 50000000,
  parameter int GAME_SECONDS  = 30,
  parameter int TARGET_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startGame,
  input  logic       bOut1,
  input  logic       bOut2,
  input  logic       bOut3,
  output logic       stopIn,
  output logic [2:0] target,
  output logic [7:0] score,
  output logic [5:0] timeLeft,
  output logic       hitPulse,
  output logic       missPulse
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int TW = (TARGET_CYCLES > 1) ? $clog2(TARGET_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [TW-1:0] TGT_LAST   = TW'(TARGET_CYCLES - 1);
  localparam logic [5:0]    ROUND_SECS = 6'(GAME_SECONDS);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [TW-1:0] ttimer, ttimer_nxt;
  logic [1:0]    cur_idx, cur_idx_nxt;
  logic [3:0]    lfsr;
  logic [2:0]    btn, btn_q, edges;
  logic [1:0]    cand_idx, new_idx;
  logic [2:0]    new_onehot;
  logic          hit, sec_tick, tgt_expire;

  logic          stop_nxt, hit_nxt, miss_nxt;
  logic [2:0]    target_nxt;
  logic [7:0]    score_nxt;
  logic [5:0]    time_nxt;

  assign btn   = {bOut3, bOut2, bOut1};
  assign edges = btn & ~btn_q;

  // Index 3 folds onto 0; a repeat of the current index is bumped to the next one mod 3.
  assign cand_idx   = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
  assign new_idx    = (cand_idx != cur_idx) ? cand_idx :
                      (cur_idx == 2'd2) ? 2'd0 : cur_idx + 2'd1;
  assign new_onehot = 3'b001 << new_idx;

  assign hit        = $onehot(edges) && (edges == target);
  assign sec_tick   = (presc == PRESC_LAST);
  // >= so a wrong press landing on the terminal count still times out on the next quiet cycle
  assign tgt_expire = (ttimer >= TGT_LAST);

  // Next-state and next-output logic for the round FSM.
  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    ttimer_nxt  = ttimer;
    cur_idx_nxt = cur_idx;
    stop_nxt    = stopIn;
    target_nxt  = target;
    score_nxt   = score;
    time_nxt    = timeLeft;
    hit_nxt     = 1'b0;
    miss_nxt    = 1'b0;
    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (startGame) begin
          state_nxt   = PLAY;
          score_nxt   = 8'd0;
          time_nxt    = ROUND_SECS;
          presc_nxt   = '0;
          ttimer_nxt  = '0;
          cur_idx_nxt = new_idx;
          target_nxt  = new_onehot;
        end
      end
      PLAY: begin
        if (!startGame) begin
          // abort: score and time stay frozen for display
          state_nxt  = IDLE;
          target_nxt = 3'b000;
        end else if (timeLeft == 6'd0) begin
          state_nxt  = DONE;
          target_nxt = 3'b000;
          stop_nxt   = 1'b1;
        end else begin
          if (sec_tick) begin
            presc_nxt = '0;
            time_nxt  = timeLeft - 6'd1;
          end else begin
            presc_nxt = presc + PW'(1);
          end
          if (hit) begin
            hit_nxt     = 1'b1;
            score_nxt   = (score == 8'hFF) ? score : score + 8'd1;
            cur_idx_nxt = new_idx;
            target_nxt  = new_onehot;
            ttimer_nxt  = '0;
          end else if (edges != 3'b000) begin
            miss_nxt   = 1'b1;
            score_nxt  = (score == 8'd0) ? score : score - 8'd1;
            ttimer_nxt = tgt_expire ? ttimer : ttimer + TW'(1);
          end else if (tgt_expire) begin
            miss_nxt    = 1'b1;
            cur_idx_nxt = new_idx;
            target_nxt  = new_onehot;
            ttimer_nxt  = '0;
          end else begin
            ttimer_nxt = ttimer + TW'(1);
          end
        end
      end
      DONE: begin
        stop_nxt = 1'b1;
        if (!startGame) begin
          stop_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        target_nxt = 3'b000;
        stop_nxt   = 1'b0;
      end
    endcase
  end

  // State, timers, outputs, button history and free-running LFSR (x^4+x^3+1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      ttimer    <= '0;
      cur_idx   <= 2'd0;
      lfsr      <= 4'b1001;
      btn_q     <= 3'b000;
      stopIn    <= 1'b0;
      target    <= 3'b000;
      score     <= 8'd0;
      timeLeft  <= 6'd0;
      hitPulse  <= 1'b0;
      missPulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      ttimer    <= ttimer_nxt;
      cur_idx   <= cur_idx_nxt;
      lfsr      <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      btn_q     <= btn;
      stopIn    <= stop_nxt;
      target    <= target_nxt;
      score     <= score_nxt;
      timeLeft  <= time_nxt;
      hitPulse  <= hit_nxt;
      missPulse <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_game_round_engine.sv
// Directed bench for game_round_engine: round timing, scoring, edge cases, saturation, abort, reset.
// Short rounds on the main instance; a long-round instance covers score saturation.
module tb_game_round_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sat_start;
  logic [2:0] btn, sat_btn;
  logic       stop_in, hit_p, miss_p;
  logic [2:0] target;
  logic [7:0] score;
  logic [5:0] time_left;
  logic       sat_stop, sat_hit, sat_miss;
  logic [2:0] sat_target;
  logic [7:0] sat_score;
  logic [5:0] sat_time;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_round_engine #(.CLKS_PER_SEC(10), .GAME_SECONDS(3), .TARGET_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .startGame(start),
    .bOut1(btn[0]), .bOut2(btn[1]), .bOut3(btn[2]),
    .stopIn(stop_in), .target(target), .score(score), .timeLeft(time_left),
    .hitPulse(hit_p), .missPulse(miss_p)
  );

  game_round_engine #(.CLKS_PER_SEC(20), .GAME_SECONDS(63), .TARGET_CYCLES(8)) u_sat (
    .clk(clk), .rst(rst), .startGame(sat_start),
    .bOut1(sat_btn[0]), .bOut2(sat_btn[1]), .bOut3(sat_btn[2]),
    .stopIn(sat_stop), .target(sat_target), .score(sat_score), .timeLeft(sat_time),
    .hitPulse(sat_hit), .missPulse(sat_miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rot3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] prev;
    int         hits;
    int         exp_tl;

    rst = 1'b1; start = 1'b0; btn = 3'b000; sat_start = 1'b0; sat_btn = 3'b000;
    #1;
    check("rst_stop",   32'(stop_in),   0);
    check("rst_target", 32'(target),    0);
    check("rst_score",  32'(score),     0);
    check("rst_time",   32'(time_left), 0);
    check("rst_hit",    32'(hit_p),     0);
    check("rst_miss",   32'(miss_p),    0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // full round with no presses
    start = 1'b1;
    tick();
    check("entry_time",   32'(time_left),         3);
    check("entry_onehot", 32'($onehot(target)),   1);
    prev = target;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_tl = (k < 10) ? 3 : (k < 20) ? 2 : (k < 30) ? 1 : 0;
      check("round_time", 32'(time_left), 32'(exp_tl));
      check("round_miss", 32'(miss_p), 32'((k % 8) == 0));
      check("round_stop", 32'(stop_in), 0);
      if ((k % 8) == 0) begin
        check("timeout_newtgt", 32'(target != prev), 1);
        prev = target;
      end
    end
    tick();
    check("done_stop",   32'(stop_in), 1);
    check("done_target", 32'(target),  0);
    btn = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_hold_stop", 32'(stop_in), 1);
      check("done_no_pulse",  32'(hit_p | miss_p), 0);
      btn = (k == 0) ? 3'b000 : 3'b010;
    end
    btn = 3'b000;
    start = 1'b0;
    tick();
    check("done_release", 32'(stop_in), 0);

    // scoring: five hits then one wrong press
    start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      prev = target;
      btn = target;
      tick();
      check("score_hit",    32'(hit_p),          1);
      check("score_newtgt", 32'(target != prev), 1);
      btn = 3'b000;
      tick();
    end
    check("score_five", 32'(score), 5);
    prev = target;
    btn = rot3(target);
    tick();
    check("wrong_miss",   32'(miss_p), 1);
    check("wrong_hit",    32'(hit_p),  0);
    check("wrong_score",  32'(score),  4);
    check("wrong_target", 32'(target), 32'(prev));
    btn = 3'b000;
    start = 1'b0;
    tick();

    // held correct button counts once
    start = 1'b1;
    tick();
    btn = target;
    hits = 0;
    repeat (20) begin
      tick();
      if (hit_p) hits++;
    end
    check("hold_one_hit", 32'(hits), 1);
    btn = 3'b000;
    start = 1'b0;
    tick();

    // wrong press at zero, then two buttons at once
    start = 1'b1;
    tick();
    btn = rot3(target);
    tick();
    check("zero_miss",  32'(miss_p), 1);
    check("zero_score", 32'(score),  0);
    btn = 3'b000;
    tick();
    btn = target | rot3(target);
    tick();
    check("dual_miss",  32'(miss_p), 1);
    check("dual_hit",   32'(hit_p),  0);
    check("dual_score", 32'(score),  0);
    btn = 3'b000;
    start = 1'b0;
    tick();

    // abort at timeLeft=2
    start = 1'b1;
    tick();
    btn = target;
    tick();
    check("abort_hit", 32'(hit_p), 1);
    btn = 3'b000;
    repeat (11) tick();
    check("abort_pre_time", 32'(time_left), 2);
    start = 1'b0;
    tick();
    check("abort_target", 32'(target),    0);
    check("abort_score",  32'(score),     1);
    check("abort_time",   32'(time_left), 2);
    for (int k = 0; k < 15; k++) begin
      tick();
      check("abort_no_stop", 32'(stop_in), 0);
    end
    check("abort_frozen_score", 32'(score),     1);
    check("abort_frozen_time",  32'(time_left), 2);
    start = 1'b1;
    tick();
    check("restart_score", 32'(score),     0);
    check("restart_time",  32'(time_left), 3);

    // asynchronous reset in the middle of play
    btn = target;
    tick();
    check("pre_rst_hit", 32'(hit_p), 1);
    rst = 1'b1;
    #1;
    check("arst_stop",   32'(stop_in),   0);
    check("arst_target", 32'(target),    0);
    check("arst_score",  32'(score),     0);
    check("arst_time",   32'(time_left), 0);
    check("arst_hit",    32'(hit_p),     0);
    check("arst_miss",   32'(miss_p),    0);
    start = 1'b0;
    btn = 3'b000;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle_tgt",  32'(target),  0);
    check("post_rst_idle_stop", 32'(stop_in), 0);
    start = 1'b1;
    tick();
    check("post_rst_onehot", 32'($onehot(target)), 1);
    check("post_rst_time",   32'(time_left),       3);
    start = 1'b0;
    tick();

    // saturation at 255 and hit/timeout collision on the long-round instance
    sat_start = 1'b1;
    tick();
    for (int i = 0; i < 260; i++) begin
      sat_btn = sat_target;
      tick();
      if (i == 254) check("sat_reach_255", 32'(sat_score), 255);
      sat_btn = 3'b000;
      tick();
    end
    check("sat_hold_255", 32'(sat_score), 255);
    repeat (6) tick();
    sat_btn = sat_target;
    tick();
    check("collide_hit",   32'(sat_hit),   1);
    check("collide_miss",  32'(sat_miss),  0);
    check("collide_score", 32'(sat_score), 255);
    sat_btn = 3'b000;
    sat_start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_round_engine.md
Name: game_round_engine

Overview:
- Game-side responder for the player-facing game controller. Consumes startGame and the three gated button levels bOut1..bOut3, and returns stopIn when the round ends.
- Runs the round timer and drives a one-hot target LED pattern. Scores correct presses.
- Sits between the game controller and the display/score logic: target, score and timeLeft feed the LED and seven-segment drivers.

Parameters:
- CLKS_PER_SEC, 50000000: clock cycles per game second (prescaler terminal count).
- GAME_SECONDS, 30: round length in seconds; 1..63.
- TARGET_CYCLES, 25000000: cycles a target stays lit before it times out as a miss.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- startGame  in  1  level from the controller; high while the round is requested.
- bOut1  in  1  button 1 level, gated by the controller.
- bOut2  in  1  button 2 level, gated by the controller.
- bOut3  in  1  button 3 level, gated by the controller.
- stopIn  out  1  round-over level back to the controller.
- target  out  3  one-hot lit target (bit0 = button 1); 0 outside PLAY.
- score  out  8  hit score.
- timeLeft  out  6  seconds remaining.
- hitPulse  out  1  one-cycle pulse on a correct press.
- missPulse  out  1  one-cycle pulse on a wrong press or target timeout.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; stopIn=0; target=0; score=0; timeLeft=0; hitPulse=0; missPulse=0.
  - Prescaler and target timer = 0; button history regs = 0; LFSR = 4'b1001.
- Button edge detection:
  - Each bOutN is registered once; edgeN = bOutN & ~bOutN_q.
  - Holding a button counts once.
- LFSR:
  - 4-bit Fibonacci, x^4+x^3+1, advances every cycle in every state.
  - Candidate index idx = (lfsr[1:0]==3) ? 0 : lfsr[1:0].
  - New target index = idx, or (cur+1) mod 3 if idx equals the current index.
- IDLE:
  - Outputs held, so score and timeLeft show the last round.
  - startGame=1 moves to PLAY next edge.
  - On entry to PLAY: score=0, timeLeft=GAME_SECONDS, prescaler=0, target timer=0, target = one-hot of new index.
- PLAY, per cycle:
  - Prescaler increments. At CLKS_PER_SEC-1 it wraps to 0 and timeLeft decrements.
  - Exactly one edge and it matches target: hitPulse=1, score+1 saturating at 255, new target, target timer=0.
  - Any other non-empty edge set (wrong button, or several edges in one cycle): missPulse=1, score-1 saturating at 0, target unchanged, timer continues.
  - No edge and target timer = TARGET_CYCLES-1: missPulse=1, new target, timer=0, score unchanged.
  - Otherwise target timer increments.
  - A hit and a target timeout in the same cycle count as a hit only.
  - When timeLeft goes 1->0, the same cycle's hit/miss is still applied. Then state=DONE, target=0, stopIn=1 on the next edge.
  - startGame=0 in PLAY aborts: state=IDLE, target=0, stopIn stays 0, score and timeLeft frozen.
- DONE:
  - stopIn=1 and buttons are ignored.
  - When startGame=0 is sampled, stopIn=0 and state=IDLE.
  - stopIn remains high for as long as startGame stays high.
- Pulses are one cycle wide and never asserted outside PLAY.

Test Plan (bench params CLKS_PER_SEC=10, GAME_SECONDS=3, TARGET_CYCLES=8):
- Reset check: pulse rst mid-PLAY -> all outputs 0 immediately (asynchronous); after release, state=IDLE; startGame raised -> target one-hot nonzero, timeLeft=3 one cycle later.
- Full round: start, no presses -> timeLeft 3->2->1->0 at 10-cycle spacing; missPulse every 8 cycles with target changing each time; stopIn=1 one cycle after timeLeft=0; drop startGame -> stopIn=0 next cycle.
- Scoring: press the lit button 5 times (1-cycle-apart releases) -> five hitPulses, score=5, target differs after each hit; one wrong press -> score=4, missPulse, target unchanged.
- Edge cases:
  - Hold the correct button for 20 cycles -> exactly one hit.
  - Press two buttons in the same cycle -> miss.
  - Wrong press at score=0 -> score stays 0.
- Saturation and collision: force 256 hits (large GAME_SECONDS) -> score stays 255; correct press on the target-timeout cycle -> hitPulse=1, missPulse=0.
- Abort: drop startGame at timeLeft=2 -> IDLE, stopIn never asserts, score and timeLeft frozen; restart -> score=0, timeLeft=3.
